// File: rtl/video_stream_capture.sv
// Capture front-end for a {hsync, vsync, rgb} game-core video stream.
// Recovers pixel coordinates from sync edges and emits expanded pixels.
module video_stream_capture #(
    parameter int   H_TOTAL  = 800,
    parameter int   V_TOTAL  = 525,
    parameter int   H_ACTIVE = 640,
    parameter int   V_ACTIVE = 480,
    parameter int   H_BP     = 48,
    parameter int   V_BP     = 33,
    parameter int   CH_W_IN  = 1,
    parameter int   CH_W_OUT = 8,
    parameter logic SYNC_ACT = 1'b0,
    parameter int   FRAME_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_en,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic [3*CH_W_IN-1:0]        rgb,
    input  logic                        start,
    input  logic [FRAME_W-1:0]          frame_limit,
    output logic                        pix_valid,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    output logic [3*CH_W_OUT-1:0]       pix_data,
    output logic                        frame_done,
    output logic [FRAME_W-1:0]          frame_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        sync_err
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_LO  = HW'(H_BP);
    localparam logic [HW-1:0] H_HI  = HW'(H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_LO  = VW'(V_BP);
    localparam logic [VW-1:0] V_HI  = VW'(V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                   hs_q;
    logic                   vs_q;
    logic                   h_tr;
    logic                   v_tr;
    logic                   h_seen;
    logic                   in_act;
    logic                   run;
    logic                   arming;
    logic                   fd_nxt;
    logic                   err_hit;
    logic                   take_pix;
    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic [FRAME_W-1:0]     limit_q;
    logic [FRAME_W-1:0]     cnt_inc;
    logic [3*CH_W_OUT-1:0]  rgb_exp;

    assign h_tr = pix_en && (hs_q == SYNC_ACT) && (hsync != SYNC_ACT);
    assign v_tr = pix_en && (vs_q == SYNC_ACT) && (vsync != SYNC_ACT);

    assign in_act = (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                    (v_cnt >= V_LO) && (v_cnt < V_HI);

    assign run      = (state == ARM) || (state == CAPTURE);
    assign busy     = run;
    assign done     = (state == DONE);
    assign arming   = start && ((state == IDLE) || (state == DONE));
    assign take_pix = pix_en && (state == CAPTURE) && in_act;
    assign cnt_inc  = frame_cnt + 1'b1;

    // First line after arming is ignored: counters may be mid-line.
    assign err_hit = (h_tr && h_seen && (h_cnt != H_MAX - 1'b1)) ||
                     (v_tr && (state == CAPTURE) &&
                      (v_cnt != V_MAX - 1'b1)) ||
                     (pix_en && (h_cnt == H_MAX));

    // MSB-first replication of each channel, truncated to output width.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        for (genvar i = 0; i < CH_W_OUT; i++) begin : g_bit
            assign rgb_exp[c*CH_W_OUT + CH_W_OUT-1-i] =
                rgb[c*CH_W_IN + CH_W_IN-1 - (i % CH_W_IN)];
        end
    end

    always_comb begin
        state_nxt = state;
        fd_nxt    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nxt = ARM;
            end
            ARM: begin
                if (v_tr) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (v_tr) begin
                    fd_nxt = 1'b1;
                    if ((limit_q != '0) && (cnt_inc == limit_q))
                        state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            hs_q       <= ~SYNC_ACT;
            vs_q       <= ~SYNC_ACT;
            h_cnt      <= '0;
            v_cnt      <= '0;
            h_seen     <= 1'b0;
            limit_q    <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            sync_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pix_en) begin
                hs_q <= hsync;
                vs_q <= vsync;
                if (h_tr)
                    h_cnt <= '0;
                else if (h_cnt != H_MAX)
                    h_cnt <= h_cnt + 1'b1;
                if (v_tr)
                    v_cnt <= '0;
                else if (h_tr && (v_cnt != V_MAX))
                    v_cnt <= v_cnt + 1'b1;
            end
            pix_valid <= take_pix;
            if (take_pix) begin
                pix_x    <= XW'(h_cnt - H_LO);
                pix_y    <= YW'(v_cnt - V_LO);
                pix_data <= rgb_exp;
            end else begin
                pix_x    <= '0;
                pix_y    <= '0;
                pix_data <= '0;
            end
            frame_done <= fd_nxt;
            if (arming) begin
                frame_cnt <= '0;
                sync_err  <= 1'b0;
                h_seen    <= 1'b0;
                limit_q   <= frame_limit;
            end else begin
                if (fd_nxt)
                    frame_cnt <= cnt_inc;
                if (run && err_hit)
                    sync_err <= 1'b1;
                if (run && h_tr)
                    h_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_stream_capture.sv
// Randomised stream bench for video_stream_capture on a reduced raster.
// Expectations come from raster position arithmetic and frame events.
module tb_video_stream_capture;

    localparam int H_TOTAL  = 24;
    localparam int V_TOTAL  = 14;
    localparam int H_ACTIVE = 10;
    localparam int V_ACTIVE = 6;
    localparam int H_BP     = 4;
    localparam int V_BP     = 3;
    localparam int CH_W_IN  = 3;
    localparam int CH_W_OUT = 8;
    localparam int FRAME_W  = 8;
    localparam int HS_W     = 3;
    localparam int VS_W     = 2;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_CAP  = 2;
    localparam int M_DONE = 3;

    logic                  clk;
    logic                  reset;
    logic                  pix_en;
    logic                  hsync;
    logic                  vsync;
    logic [3*CH_W_IN-1:0]  rgb;
    logic                  start;
    logic [FRAME_W-1:0]    frame_limit;
    logic                  pix_valid;
    logic [3:0]            pix_x;
    logic [2:0]            pix_y;
    logic [3*CH_W_OUT-1:0] pix_data;
    logic                  frame_done;
    logic [FRAME_W-1:0]    frame_cnt;
    logic                  busy;
    logic                  done;
    logic                  sync_err;

    int checks = 0;
    int fails  = 0;

    int p = 0;
    int l = 0;
    int mst = M_IDLE;
    int lim_m = 0;
    logic [FRAME_W-1:0] frames_m = '0;
    logic err_m = 1'b0;
    logic short_line = 1'b0;
    logic short_end = 1'b0;
    int fd_seen = 0;
    int fr_pix = 0;
    int first_x, first_y, last_x, last_y;

    video_stream_capture #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .H_BP(H_BP), .V_BP(V_BP),
        .CH_W_IN(CH_W_IN), .CH_W_OUT(CH_W_OUT),
        .SYNC_ACT(1'b0), .FRAME_W(FRAME_W)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .start(start), .frame_limit(frame_limit),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data(pix_data), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .busy(busy), .done(done),
        .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CH_W_OUT-1:0] expand(
        input logic [CH_W_IN-1:0] c);
        logic [CH_W_OUT-1:0] o;
        for (int i = 0; i < CH_W_OUT; i++)
            o[CH_W_OUT-1-i] = c[CH_W_IN-1 - (i % CH_W_IN)];
        return o;
    endfunction

    task automatic step();
        int gap, ex, ey;
        logic act, exp_v, exp_fd, forced;
        logic [3*CH_W_OUT-1:0] exp_d;
        gap = $urandom_range(3, 0);
        repeat (gap) begin
            pix_en = 1'b0;
            tick();
            chk("gap_valid", pix_valid, 0);
            chk("gap_done_pulse", frame_done, 0);
        end
        hsync = (p < HS_W) ? 1'b0 : 1'b1;
        vsync = (l < VS_W || (l == VS_W && p < HS_W)) ? 1'b0 : 1'b1;
        forced = (p == 14 && l == 9);
        rgb = forced ? 9'b101_000_111 : 9'($urandom);
        ex = p - HS_W - 1 - H_BP;
        ey = l - VS_W - V_BP;
        act = ex >= 0 && ex < H_ACTIVE && ey >= 0 && ey < V_ACTIVE;
        exp_v = (mst == M_CAP) && act;
        exp_d = {expand(rgb[8:6]), expand(rgb[5:3]), expand(rgb[2:0])};
        exp_fd = 1'b0;
        if (short_end && p == HS_W) begin
            if (mst == M_ARM || mst == M_CAP) err_m = 1'b1;
            short_end = 1'b0;
        end
        if (l == VS_W && p == HS_W) begin
            if (mst == M_ARM) begin
                mst = M_CAP;
                fr_pix = 0;
            end else if (mst == M_CAP) begin
                frames_m = frames_m + 1'b1;
                exp_fd = 1'b1;
                if (lim_m != 0 && int'(frames_m) == lim_m) mst = M_DONE;
            end
        end
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        chk("pix_valid", pix_valid, exp_v);
        if (exp_v) begin
            chk("pix_x", pix_x, ex);
            chk("pix_y", pix_y, ey);
            chk("pix_data", pix_data, exp_d);
            if (forced) chk("expand_101", pix_data, 24'hB600FF);
        end
        chk("frame_done", frame_done, exp_fd);
        chk("frame_cnt", frame_cnt, frames_m);
        chk("busy", busy, mst == M_ARM || mst == M_CAP);
        chk("done", done, mst == M_DONE);
        chk("sync_err", sync_err, err_m);
        if (pix_valid === 1'b1) begin
            if (fr_pix == 0) begin
                first_x = int'(pix_x);
                first_y = int'(pix_y);
            end
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            fr_pix++;
        end
        if (frame_done === 1'b1) fd_seen++;
        if (exp_fd) begin
            chk("frame_pixels", fr_pix, H_ACTIVE * V_ACTIVE);
            chk("first_xy", {first_x[15:0], first_y[15:0]}, 0);
            chk("last_xy", {last_x[15:0], last_y[15:0]},
                {16'(H_ACTIVE - 1), 16'(V_ACTIVE - 1)});
            fr_pix = 0;
        end
        p++;
        if (p >= (short_line ? H_TOTAL - 1 : H_TOTAL)) begin
            p = 0;
            l = (l + 1) % V_TOTAL;
            if (short_line) begin
                short_line = 1'b0;
                short_end = 1'b1;
            end
        end
    endtask

    task automatic do_start(input int lim);
        start = 1'b1;
        frame_limit = FRAME_W'(lim);
        tick();
        start = 1'b0;
        if (mst == M_IDLE || mst == M_DONE) begin
            mst = M_ARM;
            frames_m = '0;
            lim_m = lim;
            err_m = 1'b0;
        end
        chk("start_busy", busy, 1);
        chk("start_frame_cnt", frame_cnt, frames_m);
        chk("start_sync_err", sync_err, err_m);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_xy"}, {pix_x, pix_y}, 0);
        chk({tag, "_data"}, pix_data, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_cnt"}, frame_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, sync_err, 0);
    endtask

    initial begin
        reset = 1'b0;
        pix_en = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        rgb = '0;
        start = 1'b0;
        frame_limit = '0;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b1;

        // Two-frame capture armed mid-frame, with an ignored restart
        repeat (7 * H_TOTAL) step();
        fd_seen = 0;
        do_start(2);
        for (int i = 0; i < 1500 && frames_m != 1; i++) step();
        repeat (2 * H_TOTAL) step();
        do_start(5);
        for (int i = 0; i < 1500 && mst != M_DONE; i++) step();
        repeat (H_TOTAL) step();
        chk("s1_done", done, 1);
        chk("s1_frames", frame_cnt, 2);
        chk("s1_pulses", fd_seen, 2);
        chk("s1_err", sync_err, 0);

        // Short line in the second frame
        fd_seen = 0;
        do_start(2);
        for (int i = 0; i < 1500 && frames_m != 1; i++) step();
        for (int i = 0; i < 400 && l != 6; i++) step();
        short_line = 1'b1;
        for (int i = 0; i < 1500 && mst != M_DONE; i++) step();
        repeat (H_TOTAL) step();
        chk("s3_err", sync_err, 1);
        chk("s3_done", done, 1);
        chk("s3_frames", frame_cnt, 2);
        chk("s3_pulses", fd_seen, 2);

        // Reset in the middle of a free-running capture
        fd_seen = 0;
        do_start(0);
        chk("s5_err_cleared", sync_err, 0);
        for (int i = 0; i < 1500 && frames_m != 1; i++) step();
        for (int i = 0; i < 400 && l != 7; i++) step();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_zero("midreset");
        mst = M_IDLE;
        frames_m = '0;
        lim_m = 0;
        err_m = 1'b0;
        repeat (V_TOTAL * H_TOTAL + 40) step();
        chk("s5_pulses", fd_seen, 1);

        // Free run for three frames
        fd_seen = 0;
        do_start(0);
        for (int i = 0; i < 2000 && frames_m != 3; i++) step();
        repeat (3 * H_TOTAL) step();
        chk("s6_busy", busy, 1);
        chk("s6_done", done, 0);
        chk("s6_frames", frame_cnt, 3);
        chk("s6_pulses", fd_seen, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/video_stream_capture.md
Name: video_stream_capture

Overview:
Synthesizable capture front-end for the VGA-style {hsync, vsync, rgb} stream produced by the game cores. It recovers pixel coordinates from the sync edges, expands each colour channel to a parametrised output depth and emits a valid-qualified pixel stream. It counts frames up to a programmable limit and flags line/frame timing errors. It sits between a game core's video outputs and a frame buffer or host DMA, replacing bench-only frame capture with hardware.

Parameters:
H_TOTAL, 800, pixel clocks per line
V_TOTAL, 525, lines per frame
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_BP, 48, pixel clocks from hsync trailing edge to first active pixel
V_BP, 33, lines from vsync trailing edge to first active line
CH_W_IN, 1, input bits per colour channel
CH_W_OUT, 8, output bits per colour channel (>= CH_W_IN)
SYNC_ACT, 0, active level of hsync/vsync
FRAME_W, 8, width of frame counter/limit

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
pix_en  in  1  pixel-rate strobe (clock divider); all stream inputs sampled only when high
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
rgb  in  3*CH_W_IN  {R,G,B}, R in MSBs
start  in  1  one-cycle capture request
frame_limit  in  FRAME_W  frames to capture; 0 = free run
pix_valid  out  1  pix_x/pix_y/pix_data valid this cycle
pix_x  out  $clog2(H_ACTIVE)  active column
pix_y  out  $clog2(V_ACTIVE)  active row
pix_data  out  3*CH_W_OUT  expanded {R,G,B}
frame_done  out  1  one-cycle pulse at end of each captured frame
frame_cnt  out  FRAME_W  frames captured since start
busy  out  1  high in ARM or CAPTURE
done  out  1  high in DONE
sync_err  out  1  sticky timing error

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-low. While reset is low, all outputs are 0, counters are 0 and the FSM is IDLE. A reset mid-frame aborts the capture immediately, with no frame_done.
- Edge detect: registered copies of hsync/vsync update only on pix_en. A trailing edge is active->inactive between consecutive pix_en samples.
- h_cnt: on a pix_en sample, goes to 0 on an hsync trailing edge, otherwise increments, saturating at H_TOTAL.
- v_cnt: on an hsync trailing edge, increments, saturating at V_TOTAL. A vsync trailing edge sets v_cnt to 0 and takes priority when both edges occur on the same sample.
- Active region: H_BP <= h_cnt < H_BP+H_ACTIVE and V_BP <= v_cnt < V_BP+V_ACTIVE. In this region, pix_x = h_cnt-H_BP and pix_y = v_cnt-V_BP.
- FSM states: IDLE, ARM, CAPTURE, DONE.
  - IDLE/DONE -> ARM on start. This clears frame_cnt and sync_err.
  - start in ARM/CAPTURE is ignored.
  - ARM -> CAPTURE on the first vsync trailing edge.
  - In CAPTURE, each subsequent vsync trailing edge pulses frame_done and increments frame_cnt (wraps modulo 2^FRAME_W in free run).
  - CAPTURE -> DONE when the incremented frame_cnt == frame_limit (frame_limit != 0). frame_done pulses on that same cycle.
- pix_valid: asserted exactly one clk after a pix_en sample that is in CAPTURE and inside the active region. Data is registered and low otherwise. pix_valid is never asserted in IDLE/ARM/DONE.
- Expansion: each channel's CH_W_IN bits are replicated MSB-first and truncated to CH_W_OUT. For CH_W_IN=1, 1 -> 0xFF and 0 -> 0x00. For CH_W_IN=3, 3'b101 -> 8'b10110110.
- sync_err: set in ARM/CAPTURE if either condition below occurs; it stays set until the next accepted start. Capture continues.
  - An hsync trailing edge occurs with h_cnt+1 != H_TOTAL, ignoring the first line after arming.
  - A vsync trailing edge occurs with v_cnt != V_TOTAL-1, or with v_cnt+1 != V_TOTAL if an hsync edge coincides, ignoring the first frame.
  - h_cnt saturates at H_TOTAL.
- Mid-run behaviour: pix_en low holds all state. frame_limit is sampled on start and held.

Test Plan:
1. Default params, ideal 800x525 stream, pix_en every 4th clk, start with frame_limit=2 -> 2 frame_done pulses, done=1, frame_cnt=2. Exactly 640*480 pix_valid per frame; first valid (0,0), last (639,479). sync_err=0.
2. CH_W_IN=1, rgb=3'b101 at pixel (10,20) -> pix_data=24'hFF00FF with pix_x=10, pix_y=20, one clk after the sample. CH_W_IN=3, R=3'b101 -> R out 8'hB6.
3. One line shortened to 799 clocks in the second frame -> sync_err=1 and capture still completes. A new start clears sync_err to 0.
4. Start issued mid-frame -> no pix_valid until the next vsync trailing edge. Start while busy has no effect on frame_cnt.
5. reset low for 1 clk mid-CAPTURE -> all outputs 0 next clk, FSM IDLE, no frame_done pulse.
6. frame_limit=0, 3 frames -> busy stays 1, done=0, frame_cnt=3, three frame_done pulses.
